// File: rtl/key_event_gen.sv
// key_event_gen
//   Turns the debounced key level into discrete key events: PRESS, RELEASE,
//   LONG (held for HOLD_CYCLES) and REPEAT (every REPEAT_CYCLES after LONG).
//   Events are held in a one-entry output buffer so the consumer can take
//   them at its own pace.
//
// Ports
//   clk          system clock, sole clock domain
//   rst          synchronous, active-high reset
//   key_in       debounced key level, asynchronous to clk
//   en           1: generate events; 0: FSM held in IDLE, no new events
//   event_valid  buffered event present
//   event_code   00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
//   event_ready  consumer accepts the event when event_valid && event_ready
//   key_pressed  synchronised key level, 1 = pressed
//   overflow     sticky flag, set when an event is dropped; cleared by rst
//
// Handshake: an event transfers on every clk edge where event_valid and
// event_ready are both 1. While event_valid=1 and event_ready=0, event_code
// and event_valid do not change; any new event in that window is dropped
// and flagged through overflow.
module key_event_gen #(
  parameter int unsigned HOLD_CYCLES    = 5_000_000,
  parameter int unsigned REPEAT_CYCLES  = 1_000_000,
  parameter int unsigned CNT_W          = 24,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       en,
  output logic       event_valid,
  output logic [1:0] event_code,
  input  logic       event_ready,
  output logic       key_pressed,
  output logic       overflow
);

  localparam logic [1:0] CODE_PRESS   = 2'b00;
  localparam logic [1:0] CODE_RELEASE = 2'b01;
  localparam logic [1:0] CODE_LONG    = 2'b10;
  localparam logic [1:0] CODE_REPEAT  = 2'b11;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  // Raw key level that means "released".
  localparam logic REL_LEVEL = KEY_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic             sync1;
  logic             sync2;
  logic             key_s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             emit;
  logic [1:0]       emit_code;
  logic             accept;

  // Two-flop synchroniser; reset to the released level so no spurious PRESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= REL_LEVEL;
      sync2       <= REL_LEVEL;
      key_pressed <= 1'b0;
    end else begin
      sync1       <= key_in;
      sync2       <= sync1;
      key_pressed <= key_s;
    end
  end

  assign key_s = KEY_ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Release is tested first in every pressed state so it wins over LONG/REPEAT.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    emit       = 1'b0;
    emit_code  = CODE_PRESS;
    if (!en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_s) begin
            state_next = PRESSED;
            cnt_next   = '0;
            emit       = 1'b1;
            emit_code  = CODE_PRESS;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state_next = IDLE;
            cnt_next   = '0;
            emit       = 1'b1;
            emit_code  = CODE_RELEASE;
          end else if (cnt == HOLD_LAST) begin
            state_next = HELD;
            cnt_next   = '0;
            emit       = 1'b1;
            emit_code  = CODE_LONG;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        HELD: begin
          if (!key_s) begin
            state_next = IDLE;
            cnt_next   = '0;
            emit       = 1'b1;
            emit_code  = CODE_RELEASE;
          end else if (REPEAT_CYCLES != 0) begin
            if (cnt == REPEAT_LAST) begin
              cnt_next  = '0;
              emit      = 1'b1;
              emit_code = CODE_REPEAT;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign accept = event_valid && event_ready;

  // One-entry buffer: a new event may replace the entry being accepted in
  // the same cycle; otherwise an event arriving at a full, stalled buffer is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid <= 1'b0;
      event_code  <= CODE_PRESS;
      overflow    <= 1'b0;
    end else if (emit && (!event_valid || accept)) begin
      event_valid <= 1'b1;
      event_code  <= emit_code;
    end else if (emit) begin
      overflow <= 1'b1;
    end else if (accept) begin
      event_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen
//   Directed bench for key_event_gen. Main instance: HOLD=8, REPEAT=4,
//   active-low key. Second instance: REPEAT=0 (no auto-repeat).
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   Accepted events are logged with the count of rising edges seen so far.
module tb_key_event_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       key_in;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_code;
  logic       key_pressed;
  logic       overflow;

  logic       key_b;
  logic       ready_b;
  logic       valid_b;
  logic [1:0] code_b;
  logic       pressed_b;
  logic       overflow_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] ev_code_q[$];
  int         ev_cyc_q[$];
  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  int         b_cnt[4];
  int         b_long_cyc;

  // Clock / cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_event_gen #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(24), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .en(en),
    .event_valid(event_valid), .event_code(event_code),
    .event_ready(event_ready), .key_pressed(key_pressed), .overflow(overflow)
  );

  key_event_gen #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(0), .CNT_W(24), .KEY_ACTIVE_LOW(1'b1)
  ) dut_norep (
    .clk(clk), .rst(rst), .key_in(key_b), .en(en),
    .event_valid(valid_b), .event_code(code_b),
    .event_ready(ready_b), .key_pressed(pressed_b), .overflow(overflow_b)
  );

  // Event logger.
  always @(negedge clk) begin
    if (event_valid && event_ready) begin
      ev_code_q.push_back(event_code);
      ev_cyc_q.push_back(cyc);
    end
    if (valid_b && ready_b) begin
      b_cnt[code_b] = b_cnt[code_b] + 1;
      if (code_b == 2'b10) b_long_cyc = cyc;
    end
  end

  task automatic clear_log;
    ev_code_q.delete();
    ev_cyc_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", event_valid); end
    total++; if (event_code !== 2'b00) begin bad++; $display("FAIL reset_code: got %b want 00", event_code); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL reset_key_pressed: got %b want 0", key_pressed); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", event_valid); end
  endtask

  task automatic test_short_press;
    int c;
    @(negedge clk);
    clear_log();
    c = cyc;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL short_key_pressed: got %b want 1", key_pressed); end
    key_in = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL short_key_released: got %b want 0", key_pressed); end
    exp_q.push_back(2'b00); exp_cyc_q.push_back(c + 3);
    exp_q.push_back(2'b01); exp_cyc_q.push_back(c + 6);
    total++; if (ev_code_q.size() != exp_q.size()) begin bad++; $display("FAIL short_count: got %0d want %0d", ev_code_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= ev_code_q.size()) begin bad++; $display("FAIL short_ev[%0d]: missing, want code %0d", i, exp_q[i]); end
      else if (ev_code_q[i] !== exp_q[i] || ev_cyc_q[i] != exp_cyc_q[i]) begin
        bad++; $display("FAIL short_ev[%0d]: got code %0d cyc %0d want code %0d cyc %0d", i, ev_code_q[i], ev_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_long_hold;
    int c;
    @(negedge clk);
    clear_log();
    c = cyc;
    key_in = 1'b0;
    repeat (30) @(negedge clk);
    key_in = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(2'b00); exp_cyc_q.push_back(c + 3);
    exp_q.push_back(2'b10); exp_cyc_q.push_back(c + 11);
    for (int r = 0; r < 5; r++) begin
      exp_q.push_back(2'b11); exp_cyc_q.push_back(c + 15 + 4 * r);
    end
    exp_q.push_back(2'b01); exp_cyc_q.push_back(c + 33);
    total++; if (ev_code_q.size() != exp_q.size()) begin bad++; $display("FAIL long_count: got %0d want %0d", ev_code_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= ev_code_q.size()) begin bad++; $display("FAIL long_ev[%0d]: missing, want code %0d", i, exp_q[i]); end
      else if (ev_code_q[i] !== exp_q[i] || ev_cyc_q[i] != exp_cyc_q[i]) begin
        bad++; $display("FAIL long_ev[%0d]: got code %0d cyc %0d want code %0d cyc %0d", i, ev_code_q[i], ev_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL long_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_overflow;
    @(negedge clk);
    clear_log();
    event_ready = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    key_in = 1'b1;
    @(negedge clk);
    total++; if (event_valid !== 1'b1 || event_code !== 2'b00) begin bad++; $display("FAIL ovf_press_held: got v=%b code=%b want v=1 code=00", event_valid, event_code); end
    @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
    @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
    repeat (4) @(negedge clk);
    total++; if (event_valid !== 1'b1 || event_code !== 2'b00) begin bad++; $display("FAIL ovf_stable: got v=%b code=%b want v=1 code=00", event_valid, event_code); end
    event_ready = 1'b1;
    @(negedge clk);
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain: got %b want 0", event_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_release_at_long;
    int c;
    @(negedge clk);
    clear_log();
    c = cyc;
    key_in = 1'b0;
    repeat (8) @(negedge clk);
    key_in = 1'b1;
    repeat (12) @(negedge clk);
    exp_q.push_back(2'b00); exp_cyc_q.push_back(c + 3);
    exp_q.push_back(2'b01); exp_cyc_q.push_back(c + 11);
    total++; if (ev_code_q.size() != exp_q.size()) begin bad++; $display("FAIL rel_long_count: got %0d want %0d", ev_code_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= ev_code_q.size()) begin bad++; $display("FAIL rel_long_ev[%0d]: missing, want code %0d", i, exp_q[i]); end
      else if (ev_code_q[i] !== exp_q[i] || ev_cyc_q[i] != exp_cyc_q[i]) begin
        bad++; $display("FAIL rel_long_ev[%0d]: got code %0d cyc %0d want code %0d cyc %0d", i, ev_code_q[i], ev_cyc_q[i], exp_q[i], exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_no_repeat;
    int c;
    @(negedge clk);
    for (int i = 0; i < 4; i++) b_cnt[i] = 0;
    b_long_cyc = -1;
    c = cyc;
    key_b = 1'b0;
    repeat (40) @(negedge clk);
    key_b = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (b_cnt[0] != 1) begin bad++; $display("FAIL norep_press: got %0d want 1", b_cnt[0]); end
    total++; if (b_cnt[2] != 1) begin bad++; $display("FAIL norep_long: got %0d want 1", b_cnt[2]); end
    total++; if (b_cnt[3] != 0) begin bad++; $display("FAIL norep_repeat: got %0d want 0", b_cnt[3]); end
    total++; if (b_cnt[1] != 1) begin bad++; $display("FAIL norep_release: got %0d want 1", b_cnt[1]); end
    total++; if (b_long_cyc != c + 11) begin bad++; $display("FAIL norep_long_cyc: got %0d want %0d", b_long_cyc, c + 11); end
  endtask

  task automatic test_rst_mid_hold;
    int d;
    @(negedge clk);
    clear_log();
    event_ready = 1'b0;
    key_in = 1'b0;
    repeat (14) @(negedge clk);
    total++; if (event_valid !== 1'b1) begin bad++; $display("FAIL rst_pre_valid: got %b want 1", event_valid); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (event_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", event_valid); end
    total++; if (event_code !== 2'b00) begin bad++; $display("FAIL rst_mid_code: got %b want 00", event_code); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL rst_mid_key_pressed: got %b want 0", key_pressed); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
    rst = 1'b0;
    event_ready = 1'b1;
    clear_log();
    d = cyc;
    repeat (6) @(negedge clk);
    total++;
    if (ev_code_q.size() < 1) begin bad++; $display("FAIL rst_repress: no event, want PRESS at cyc %0d", d + 3); end
    else if (ev_code_q[0] !== 2'b00 || ev_cyc_q[0] != d + 3) begin
      bad++; $display("FAIL rst_repress: got code %0d cyc %0d want code 0 cyc %0d", ev_code_q[0], ev_cyc_q[0], d + 3);
    end
    key_in = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_post_overflow: got %b want 0", overflow); end
  endtask

  task automatic test_enable;
    int e;
    @(negedge clk);
    clear_log();
    key_in = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (ev_code_q.size() != 1) begin bad++; $display("FAIL en_off_count: got %0d want 1", ev_code_q.size()); end
    e = cyc;
    en = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (ev_code_q.size() < 2) begin bad++; $display("FAIL en_repress: no event, want PRESS at cyc %0d", e + 1); end
    else if (ev_code_q[1] !== 2'b00 || ev_cyc_q[1] != e + 1) begin
      bad++; $display("FAIL en_repress: got code %0d cyc %0d want code 0 cyc %0d", ev_code_q[1], ev_cyc_q[1], e + 1);
    end
    key_in = 1'b1;
    repeat (8) @(negedge clk);
    total++;
    if (ev_code_q.size() != 3) begin bad++; $display("FAIL en_release_count: got %0d want 3", ev_code_q.size()); end
    else if (ev_code_q[2] !== 2'b01) begin bad++; $display("FAIL en_release_code: got %0d want 1", ev_code_q[2]); end
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    key_in      = 1'b1;
    key_b       = 1'b1;
    event_ready = 1'b1;
    ready_b     = 1'b1;
    b_long_cyc  = -1;
    test_reset();
    test_short_press();
    test_long_hold();
    test_overflow();
    test_release_at_long();
    test_no_repeat();
    test_rst_mid_hold();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
